// File: rtl/model_render_sequencer_pkg.sv
// Shared render constants and sequencer state encoding. The primitive assembler
// imports the same package so both blocks agree on triangle-count widths.
package model_render_sequencer_pkg;

    localparam int MAX_MODEL_COUNT    = 16;
    localparam int MAX_TRIANGLE_COUNT = 16384;
    localparam int CYCLE_CNT_WIDTH    = 32;
    localparam int MW                 = $clog2(MAX_MODEL_COUNT);
    localparam int TW                 = $clog2(MAX_TRIANGLE_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_ISSUE,
        S_RUN,
        S_NEXT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/model_render_sequencer.sv
// Frame scheduler: walks the model table, starts the primitive assembler once per
// non-empty model, and reports frame completion, abort status and cycle count.
module model_render_sequencer
    import model_render_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_frame_start,
    input  logic [MW:0]                i_num_models,
    input  logic                       i_abort,
    output logic [MW-1:0]              o_model_addr,
    output logic                       o_model_read_en,
    input  logic [TW-1:0]              i_model_num_triangles,
    output logic                       o_pa_start,
    output logic [TW-1:0]              o_pa_num_triangles,
    input  logic                       i_pa_ready,
    input  logic                       i_pa_finished,
    output logic [MW-1:0]              o_model_id,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic                       o_aborted,
    output logic [CYCLE_CNT_WIDTH-1:0] o_frame_cycles
);

    seq_state_t    state;
    logic [MW:0]   num_models;
    logic [MW-1:0] index;
    logic [TW-1:0] r_tri;
    logic          abort_q;
    logic          abort_any;
    logic          last_model;

    // An abort arriving in the same cycle as the decision counts immediately.
    assign abort_any  = abort_q | i_abort;
    assign last_model = ((MW+1)'(index) + (MW+1)'(1)) == num_models;

    // Mealy start: the pulse coincides with the cycle the assembler reports ready.
    assign o_pa_start         = (state == S_ISSUE) && i_pa_ready && !abort_any;
    assign o_pa_num_triangles = r_tri;
    assign o_model_read_en    = (state == S_FETCH);
    assign o_model_addr       = index;
    assign o_model_id         = (state == S_IDLE) ? '0 : index;
    assign o_busy             = (state != S_IDLE);
    assign o_frame_done       = (state == S_DONE);

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            num_models     <= '0;
            index          <= '0;
            r_tri          <= '0;
            abort_q        <= 1'b0;
            o_aborted      <= 1'b0;
            o_frame_cycles <= '0;
        end else begin
            if (state != S_IDLE) begin
                abort_q <= abort_q | i_abort;
                if (~&o_frame_cycles)
                    o_frame_cycles <= o_frame_cycles + CYCLE_CNT_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        num_models     <= i_num_models;
                        index          <= '0;
                        o_frame_cycles <= '0;
                        o_aborted      <= 1'b0;
                        abort_q        <= 1'b0;
                        state          <= (i_num_models == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT_DATA;
                S_WAIT_DATA: begin
                    r_tri <= i_model_num_triangles;
                    state <= (i_model_num_triangles != '0) ? S_ISSUE : S_NEXT;
                end
                S_ISSUE: begin
                    if (abort_any)
                        state <= S_NEXT;
                    else if (i_pa_ready)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (i_pa_finished)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    if (abort_any || last_model) begin
                        o_aborted <= abort_any;
                        state     <= S_DONE;
                    end else begin
                        index <= index + MW'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    abort_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_model_render_sequencer.sv
// Directed bench for model_render_sequencer with a model-table RAM and a
// primitive-assembler stub that finishes 10 cycles after each start.
module tb_model_render_sequencer;
    import model_render_sequencer_pkg::*;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic                       i_frame_start;
    logic [MW:0]                i_num_models;
    logic                       i_abort;
    logic [MW-1:0]              o_model_addr;
    logic                       o_model_read_en;
    logic [TW-1:0]              i_model_num_triangles;
    logic                       o_pa_start;
    logic [TW-1:0]              o_pa_num_triangles;
    logic                       i_pa_ready;
    logic                       i_pa_finished;
    logic [MW-1:0]              o_model_id;
    logic                       o_busy;
    logic                       o_frame_done;
    logic                       o_aborted;
    logic [CYCLE_CNT_WIDTH-1:0] o_frame_cycles;

    model_render_sequencer dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .i_frame_start         (i_frame_start),
        .i_num_models          (i_num_models),
        .i_abort               (i_abort),
        .o_model_addr          (o_model_addr),
        .o_model_read_en       (o_model_read_en),
        .i_model_num_triangles (i_model_num_triangles),
        .o_pa_start            (o_pa_start),
        .o_pa_num_triangles    (o_pa_num_triangles),
        .i_pa_ready            (i_pa_ready),
        .i_pa_finished         (i_pa_finished),
        .o_model_id            (o_model_id),
        .o_busy                (o_busy),
        .o_frame_done          (o_frame_done),
        .o_aborted             (o_aborted),
        .o_frame_cycles        (o_frame_cycles)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model table: synchronous RAM with one cycle of read latency.
    logic [TW-1:0] mem [MAX_MODEL_COUNT];
    always @(posedge clk) begin
        if (o_model_read_en) i_model_num_triangles <= mem[o_model_addr];
    end

    // Assembler stub: finish pulse 10 cycles after each observed start.
    int cd     = 0;
    int fin_cyc = -1;
    always @(negedge clk) begin
        i_pa_finished = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                i_pa_finished = 1'b1;
                fin_cyc = cyc;
            end
        end
        if (o_pa_start) cd = 10;
    end

    // Event log, sampled mid-cycle.
    int start_cnt = 0;
    int read_cnt  = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int start_tri[$];
    int start_cyc[$];
    always @(negedge clk) begin
        if (o_pa_start) begin
            start_cnt++;
            start_tri.push_back(int'(o_pa_num_triangles));
            start_cyc.push_back(cyc);
        end
        if (o_model_read_en) read_cnt++;
        if (o_frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        start_cnt = 0;
        read_cnt  = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        start_tri.delete();
        start_cyc.delete();
    endtask

    task automatic start_frame(input int n);
        clear_log();
        i_num_models  = (MW+1)'(n);
        i_frame_start = 1'b1;
        acc = cyc;
        next_cycle();
        i_frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            next_cycle();
            k++;
        end
        if (done_cnt == 0) check("frame_done_timeout", 0, 1);
        next_cycle();
    endtask

    initial begin
        rstn = 1'b0;
        i_frame_start = 1'b0;
        i_num_models = '0;
        i_abort = 1'b0;
        i_pa_ready = 1'b1;
        i_pa_finished = 1'b0;
        i_model_num_triangles = '0;
        for (int i = 0; i < MAX_MODEL_COUNT; i++) mem[i] = '0;
        repeat (3) next_cycle();
        check("rst_busy", o_busy, 0);
        check("rst_cycles", o_frame_cycles, 0);
        check("rst_pa_start", o_pa_start, 0);
        check("rst_read_en", o_model_read_en, 0);
        check("rst_done", o_frame_done, 0);
        rstn = 1'b1;
        next_cycle();

        // Three models, all issued.
        mem[0] = 5; mem[1] = 7; mem[2] = 2;
        start_frame(3);
        check("t1_busy", o_busy, 1);
        wait_done(200);
        check("t1_starts", start_cnt, 3);
        check("t1_tri0", start_tri.size() > 0 ? start_tri[0] : -1, 5);
        check("t1_tri1", start_tri.size() > 1 ? start_tri[1] : -1, 7);
        check("t1_tri2", start_tri.size() > 2 ? start_tri[2] : -1, 2);
        check("t1_first_start_cyc", start_cyc.size() > 0 ? start_cyc[0] - acc : -1, 3);
        check("t1_done_after_fin", done_cyc - fin_cyc, 2);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_reads", read_cnt, 3);
        check("t1_aborted", o_aborted, 0);
        check("t1_cycles", o_frame_cycles, 43);
        check("t1_idle_id", o_model_id, 0);

        // Zero-triangle models are skipped.
        mem[0] = 0; mem[1] = 4; mem[2] = 0;
        start_frame(3);
        wait_done(200);
        check("t2_starts", start_cnt, 1);
        check("t2_tri", start_tri.size() > 0 ? start_tri[0] : -1, 4);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_cycles", o_frame_cycles, 21);

        // Empty frame.
        start_frame(0);
        wait_done(20);
        check("t3_done_cyc", done_cyc - acc, 1);
        check("t3_cycles", o_frame_cycles, 1);
        check("t3_reads", read_cnt, 0);
        check("t3_starts", start_cnt, 0);

        // Assembler not ready for 20 cycles in ISSUE.
        mem[0] = 9;
        i_pa_ready = 1'b0;
        start_frame(1);
        while (cyc < acc + 23) next_cycle();
        check("t4_no_start_while_busy_pa", start_cnt, 0);
        check("t4_busy_wait", o_busy, 1);
        i_pa_ready = 1'b1;
        wait_done(100);
        check("t4_start_cyc", start_cyc.size() > 0 ? start_cyc[0] - acc : -1, 23);
        check("t4_cycles", o_frame_cycles, 35);

        // Abort while model 1 of 4 runs.
        mem[0] = 3; mem[1] = 6; mem[2] = 8; mem[3] = 1;
        start_frame(4);
        while (cyc < acc + 20) next_cycle();
        check("t5_model_id", o_model_id, 1);
        i_abort = 1'b1;
        next_cycle();
        i_abort = 1'b0;
        wait_done(200);
        check("t5_starts", start_cnt, 2);
        check("t5_tri1", start_tri.size() > 1 ? start_tri[1] : -1, 6);
        check("t5_done_cyc", done_cyc - acc, 29);
        check("t5_aborted", o_aborted, 1);

        // Reset mid-RUN; the stale finish pulse then lands in IDLE.
        mem[0] = 5;
        start_frame(1);
        check("t6_aborted_cleared", o_aborted, 0);
        while (cyc < acc + 6) next_cycle();
        rstn = 1'b0;
        #1;
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_cycles", o_frame_cycles, 0);
        check("t6_rst_ntri", o_pa_num_triangles, 0);
        check("t6_rst_done", o_frame_done, 0);
        next_cycle();
        rstn = 1'b1;
        repeat (15) next_cycle();
        check("t6_idle_after_stale_finish", o_busy, 0);

        // Second start while busy is ignored.
        mem[0] = 4;
        start_frame(1);
        while (cyc < acc + 5) next_cycle();
        i_num_models  = 3;
        i_frame_start = 1'b1;
        next_cycle();
        i_frame_start = 1'b0;
        wait_done(100);
        check("t7_done_cyc", done_cyc - acc, 15);
        check("t7_cycles", o_frame_cycles, 15);
        repeat (20) next_cycle();
        check("t7_starts", start_cnt, 1);
        check("t7_done_cnt", done_cnt, 1);
        check("t7_idle", o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
